// File: rtl/spmp_check_ctrl.sv
// spmp_check_ctrl
//   Shares one combinational spmp checker between NR_REQ requesters. Accepts
//   one access at a time in round-robin order. It looks up the access's first
//   byte. When the access spans two 4-byte granules, it also looks up the
//   last byte. It ANDs the lookup results and returns one allow/deny pulse to
//   the requester that owns the access.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   req_valid_i/ready_o   per-requester handshake (ready is one-hot or zero)
//   req_addr/size/access/priv_i   per-requester access description
//   rsp_valid_o           one-cycle response pulse to the owner
//   rsp_allow_o           combined result, valid with rsp_valid_o
//   chk_valid/addr/access/priv_o  lookup driven into the spmp instance
//   chk_allow_i           spmp allow, combinational from chk_addr_o
//   cfg_write_i           spmp CSR write: restart the lookup sequence
//   flush_i               abandon the in-flight access, no response

// Minimal stand-in for the core's riscv package types so this block builds on
// its own; drop it when linking against the full core package.
package riscv;
    typedef enum logic [2:0] {
        ACCESS_NONE  = 3'b000,
        ACCESS_READ  = 3'b001,
        ACCESS_WRITE = 3'b010,
        ACCESS_EXEC  = 3'b100
    } pmp_access_t;

    typedef enum logic [1:0] {
        PRIV_LVL_U = 2'b00,
        PRIV_LVL_S = 2'b01,
        PRIV_LVL_M = 2'b11
    } priv_lvl_t;
endpackage

// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for a request; arbitration and acceptance happen here
// FIRST  | checker looks up the first byte of the access
// SECOND | checker looks up the last byte (granule-crossing accesses only)
// RESP   | response pulse to the owning requester
module spmp_check_ctrl #(
    parameter int unsigned PLEN   = 34,
    parameter int unsigned NR_REQ = 2
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [NR_REQ-1:0]                   req_valid_i,
    output logic [NR_REQ-1:0]                   req_ready_o,
    input  logic [NR_REQ-1:0][PLEN-1:0]         req_addr_i,
    input  logic [NR_REQ-1:0][1:0]              req_size_i,
    input  riscv::pmp_access_t [NR_REQ-1:0]     req_access_i,
    input  riscv::priv_lvl_t   [NR_REQ-1:0]     req_priv_i,
    output logic [NR_REQ-1:0]                   rsp_valid_o,
    output logic                                rsp_allow_o,
    output logic                                chk_valid_o,
    output logic [PLEN-1:0]                     chk_addr_o,
    output riscv::pmp_access_t                  chk_access_o,
    output riscv::priv_lvl_t                    chk_priv_o,
    input  logic                                chk_allow_i,
    input  logic                                cfg_write_i,
    input  logic                                flush_i
);

    localparam int unsigned IDX_W = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FIRST,
        S_SECOND,
        S_RESP
    } state_t;

    state_t             r_state;
    logic [IDX_W-1:0]   r_rr;
    logic [IDX_W-1:0]   r_owner;
    logic [PLEN-1:0]    r_a;
    logic [PLEN-1:0]    r_e;
    logic               r_ovf;
    logic               r_cross;
    logic               r_allow;
    logic [PLEN-1:0]    r_chk_addr;
    riscv::pmp_access_t r_chk_access;
    riscv::priv_lvl_t   r_chk_priv;

    logic [2*NR_REQ-1:0] w_rot;
    logic                w_any;
    logic [IDX_W-1:0]    w_off;
    logic [IDX_W-1:0]    w_gnt;
    logic [IDX_W-1:0]    w_gnt_inc;
    logic                w_accept;
    logic [PLEN-1:0]     w_sel_addr;
    logic [1:0]          w_sel_size;
    logic [PLEN:0]       w_sel_e;

    // Index addition modulo NR_REQ (NR_REQ need not be a power of two).
    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] x,
                                                  input logic [IDX_W-1:0] y);
        logic [IDX_W:0] sum;
        sum = {1'b0, x} + {1'b0, y};
        if (sum >= (IDX_W+1)'(NR_REQ))
            sum = sum - (IDX_W+1)'(NR_REQ);
        return sum[IDX_W-1:0];
    endfunction

    // Rotate the valid vector so bit 0 is the requester at r_rr.
    // The lowest set bit after rotation is the round-robin winner.
    always_comb begin
        w_rot = {req_valid_i, req_valid_i} >> r_rr;
        w_any = 1'b0;
        w_off = '0;
        for (int i = NR_REQ - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_any = 1'b1;
                w_off = IDX_W'(i);
            end
        end
    end

    assign w_gnt      = wrap_add(r_rr, w_off);
    assign w_gnt_inc  = wrap_add(w_gnt, IDX_W'(1));
    assign w_accept   = (r_state == S_IDLE) && w_any && !flush_i && !rst_i;
    assign w_sel_addr = req_addr_i[w_gnt];
    assign w_sel_size = req_size_i[w_gnt];
    // One extra bit keeps the carry out of the top address bit.
    assign w_sel_e    = {1'b0, w_sel_addr} + ((PLEN+1)'(1) << w_sel_size) - (PLEN+1)'(1);

    assign req_ready_o  = w_accept ? (NR_REQ'(1) << w_gnt) : '0;
    assign rsp_valid_o  = (r_state == S_RESP && !flush_i && !rst_i) ? (NR_REQ'(1) << r_owner) : '0;
    assign rsp_allow_o  = r_allow;
    assign chk_valid_o  = (r_state == S_FIRST) || (r_state == S_SECOND);
    assign chk_addr_o   = r_chk_addr;
    assign chk_access_o = r_chk_access;
    assign chk_priv_o   = r_chk_priv;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= S_IDLE;
            r_rr         <= '0;
            r_owner      <= '0;
            r_a          <= '0;
            r_e          <= '0;
            r_ovf        <= 1'b0;
            r_cross      <= 1'b0;
            r_allow      <= 1'b0;
            r_chk_addr   <= '0;
            r_chk_access <= riscv::ACCESS_NONE;
            r_chk_priv   <= riscv::PRIV_LVL_U;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_owner      <= w_gnt;
                        r_rr         <= w_gnt_inc;
                        r_a          <= w_sel_addr;
                        r_e          <= w_sel_e[PLEN-1:0];
                        r_ovf        <= w_sel_e[PLEN];
                        r_cross      <= w_sel_addr[PLEN-1:2] != w_sel_e[PLEN-1:2];
                        r_allow      <= 1'b1;
                        // The checker inputs are loaded on entry to FIRST.
                        r_chk_addr   <= w_sel_addr;
                        r_chk_access <= req_access_i[w_gnt];
                        r_chk_priv   <= req_priv_i[w_gnt];
                        r_state      <= S_FIRST;
                    end
                end
                S_FIRST: begin
                    if (flush_i) begin
                        r_state <= S_IDLE;
                    end else if (cfg_write_i) begin
                        r_allow <= 1'b1;
                        r_chk_addr <= r_a;
                        r_state <= S_FIRST;
                    end else begin
                        // A wrapping last byte is denied without a second lookup.
                        r_allow <= r_allow & chk_allow_i & ~r_ovf;
                        if (!r_ovf && r_cross) begin
                            r_chk_addr <= r_e;
                            r_state    <= S_SECOND;
                        end else begin
                            r_state <= S_RESP;
                        end
                    end
                end
                S_SECOND: begin
                    if (flush_i) begin
                        r_state <= S_IDLE;
                    end else if (cfg_write_i) begin
                        r_allow    <= 1'b1;
                        r_chk_addr <= r_a;
                        r_state    <= S_FIRST;
                    end else begin
                        r_allow <= r_allow & chk_allow_i;
                        r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spmp_check_ctrl.sv
module tb_spmp_check_ctrl;

    localparam int PLEN   = 34;
    localparam int NR_REQ = 2;

    logic                              clk = 1'b0;
    logic                              rst_i;
    logic [NR_REQ-1:0]                 req_valid_i;
    logic [NR_REQ-1:0]                 req_ready_o;
    logic [NR_REQ-1:0][PLEN-1:0]       req_addr_i;
    logic [NR_REQ-1:0][1:0]            req_size_i;
    riscv::pmp_access_t [NR_REQ-1:0]   req_access_i;
    riscv::priv_lvl_t   [NR_REQ-1:0]   req_priv_i;
    logic [NR_REQ-1:0]                 rsp_valid_o;
    logic                              rsp_allow_o;
    logic                              chk_valid_o;
    logic [PLEN-1:0]                   chk_addr_o;
    riscv::pmp_access_t                chk_access_o;
    riscv::priv_lvl_t                  chk_priv_o;
    logic                              chk_allow_i;
    logic                              cfg_write_i;
    logic                              flush_i;

    // Checker stand-in: denies one 4-byte granule class (addr[4:2]) when enabled.
    logic       bad_en;
    logic [2:0] bad_sel;

    int checks = 0;
    int errors = 0;

    function automatic logic perm(input logic [PLEN-1:0] ad, input logic en, input logic [2:0] sel);
        return !(en && (ad[4:2] == sel));
    endfunction

    assign chk_allow_i = perm(chk_addr_o, bad_en, bad_sel);

    always #5 clk = ~clk;

    spmp_check_ctrl #(.PLEN(PLEN), .NR_REQ(NR_REQ)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_addr_i   (req_addr_i),
        .req_size_i   (req_size_i),
        .req_access_i (req_access_i),
        .req_priv_i   (req_priv_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_allow_o  (rsp_allow_o),
        .chk_valid_o  (chk_valid_o),
        .chk_addr_o   (chk_addr_o),
        .chk_access_o (chk_access_o),
        .chk_priv_o   (chk_priv_o),
        .chk_allow_i  (chk_allow_i),
        .cfg_write_i  (cfg_write_i),
        .flush_i      (flush_i)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: actual=%0h required=%0h", nm, $time, act, exp);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // One job = list of byte addresses to look up plus a forced-deny flag.
    bit                 m_on = 0;
    bit                 m_busy = 0;
    int                 m_owner;
    int                 m_rr = 0;
    logic [PLEN-1:0]    m_look[$];
    int                 m_k;
    bit                 m_allow;
    bit                 m_deny;
    logic [PLEN-1:0]    m_last = '0;
    riscv::pmp_access_t m_acc;
    riscv::priv_lvl_t   m_priv;

    function automatic int rr_pick(input logic [NR_REQ-1:0] v, input int start);
        for (int i = 0; i < NR_REQ; i++) begin
            int j = (start + i) % NR_REQ;
            if (v[j]) return j;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        int g;
        logic [NR_REQ-1:0] e_ready;
        logic [NR_REQ-1:0] e_rsp;
        bit e_cv;
        logic [PLEN-1:0] e_ca;
        if (m_on) begin
            g = rr_pick(req_valid_i, m_rr);
            e_ready = (!m_busy && !rst_i && !flush_i && g >= 0) ? (NR_REQ'(1) << g) : '0;
            e_cv = m_busy && (m_k < m_look.size());
            e_ca = e_cv ? m_look[m_k] : m_last;
            e_rsp = (m_busy && m_k == m_look.size() && !flush_i && !rst_i) ? (NR_REQ'(1) << m_owner) : '0;
            check("m_ready", req_ready_o, e_ready);
            check("m_chk_valid", chk_valid_o, e_cv);
            check("m_chk_addr", chk_addr_o, e_ca);
            check("m_rsp_valid", rsp_valid_o, e_rsp);
            if (e_rsp != 0) check("m_rsp_allow", rsp_allow_o, m_allow && !m_deny);
            if (e_cv) begin
                check("m_chk_access", chk_access_o, m_acc);
                check("m_chk_priv", chk_priv_o, m_priv);
            end
        end
    end

    always @(posedge clk) begin
        int g;
        logic [63:0] last;
        logic [PLEN-1:0] a;
        logic [PLEN-1:0] e;
        if (rst_i) begin
            m_on = 1; m_busy = 0; m_rr = 0; m_last = '0; m_allow = 0;
        end else if (m_on) begin
            if (m_busy && m_k < m_look.size()) m_last = m_look[m_k];
            if (flush_i) begin
                m_busy = 0;
            end else if (!m_busy) begin
                g = rr_pick(req_valid_i, m_rr);
                if (g >= 0) begin
                    a = req_addr_i[g];
                    last = 64'(a) + (64'd1 << req_size_i[g]) - 64'd1;
                    e = last[PLEN-1:0];
                    m_deny = last >= (64'd1 << PLEN);
                    m_look.delete();
                    m_look.push_back(a);
                    if (!m_deny && (a >> 2) != (e >> 2)) m_look.push_back(e);
                    m_owner = g; m_acc = req_access_i[g]; m_priv = req_priv_i[g];
                    m_k = 0; m_allow = 1; m_busy = 1;
                    m_rr = (g + 1) % NR_REQ;
                end
            end else if (m_k < m_look.size()) begin
                if (cfg_write_i) begin
                    m_k = 0; m_allow = 1;
                end else begin
                    m_allow = m_allow & perm(m_look[m_k], bad_en, bad_sel);
                    m_k++;
                end
            end else begin
                m_busy = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic nxt();
        @(posedge clk); #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input logic [PLEN-1:0] a, input logic [1:0] sz,
                           input riscv::pmp_access_t acc, input riscv::priv_lvl_t pv);
        req_valid_i[i]  = 1'b1;
        req_addr_i[i]   = a;
        req_size_i[i]   = sz;
        req_access_i[i] = acc;
        req_priv_i[i]   = pv;
    endtask

    task automatic new_req(input int i);
        logic [63:0] r64;
        logic [PLEN-1:0] a;
        riscv::pmp_access_t acc;
        riscv::priv_lvl_t pv;
        r64 = {$urandom(), $urandom()};
        case ($urandom_range(0, 3))
            0: a = r64[PLEN-1:0];
            1: a = 34'h3_FFFF_FFF8 + PLEN'($urandom_range(0, 7));
            2: a = {r64[PLEN-1:2], 2'b00} + PLEN'($urandom_range(1, 3));
            default: a = PLEN'($urandom_range(0, 63));
        endcase
        case ($urandom_range(0, 2))
            0: acc = riscv::ACCESS_READ;
            1: acc = riscv::ACCESS_WRITE;
            default: acc = riscv::ACCESS_EXEC;
        endcase
        case ($urandom_range(0, 2))
            0: pv = riscv::PRIV_LVL_U;
            1: pv = riscv::PRIV_LVL_S;
            default: pv = riscv::PRIV_LVL_M;
        endcase
        set_req(i, a, 2'($urandom_range(0, 3)), acc, pv);
    endtask

    initial begin
        #2_000_000;
        errors++;
        $display("FAIL watchdog: simulation did not complete");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int gcyc[4];
        int gidx[4];
        int ng;
        logic [NR_REQ-1:0] gs;

        rst_i = 1; flush_i = 0; cfg_write_i = 0; bad_en = 0; bad_sel = 0;
        req_valid_i = '0;
        for (int i = 0; i < NR_REQ; i++) begin
            req_addr_i[i] = '0; req_size_i[i] = '0;
            req_access_i[i] = riscv::ACCESS_READ; req_priv_i[i] = riscv::PRIV_LVL_U;
        end
        repeat (3) nxt();
        smp();
        check("rst_ready", req_ready_o, 0);
        check("rst_rsp_valid", rsp_valid_o, 0);
        check("rst_rsp_allow", rsp_allow_o, 0);
        check("rst_chk_valid", chk_valid_o, 0);
        check("rst_chk_addr", chk_addr_o, 0);

        // aligned word load
        nxt(); rst_i = 0;
        set_req(0, 34'h0_8000_0000, 2'd2, riscv::ACCESS_READ, riscv::PRIV_LVL_S);
        smp(); check("al_ready", req_ready_o, 2'b01);
        nxt(); req_valid_i[0] = 0;
        smp(); check("al_chk_valid", chk_valid_o, 1); check("al_chk_addr", chk_addr_o, 34'h0_8000_0000);
        nxt();
        smp(); check("al_rsp_valid", rsp_valid_o, 2'b01); check("al_rsp_allow", rsp_allow_o, 1);
        check("al_no_second", chk_valid_o, 0);

        // granule crossing, second lookup denied
        nxt(); bad_en = 1; bad_sel = 3'd0;
        set_req(1, 34'h0_8000_0FFE, 2'd2, riscv::ACCESS_WRITE, riscv::PRIV_LVL_U);
        smp(); check("cr_ready", req_ready_o, 2'b10);
        nxt(); req_valid_i[1] = 0;
        smp(); check("cr_first", chk_addr_o, 34'h0_8000_0FFE);
        nxt();
        smp(); check("cr_second", chk_addr_o, 34'h0_8000_1001); check("cr_second_v", chk_valid_o, 1);
        nxt();
        smp(); check("cr_rsp_valid", rsp_valid_o, 2'b10); check("cr_rsp_allow", rsp_allow_o, 0);

        // wrap-around past the top of the address space
        nxt(); bad_en = 0;
        set_req(0, 34'h3_FFFF_FFFC, 2'd3, riscv::ACCESS_READ, riscv::PRIV_LVL_S);
        smp(); check("wr_ready", req_ready_o, 2'b01);
        nxt(); req_valid_i[0] = 0;
        smp(); check("wr_chk_valid", chk_valid_o, 1); check("wr_chk_addr", chk_addr_o, 34'h3_FFFF_FFFC);
        nxt();
        smp(); check("wr_rsp_valid", rsp_valid_o, 2'b01); check("wr_rsp_allow", rsp_allow_o, 0);
        check("wr_no_second", chk_valid_o, 0);

        // config write during SECOND restarts the lookups
        nxt(); bad_en = 1; bad_sel = 3'd0;
        set_req(1, 34'h0_8000_0FFE, 2'd2, riscv::ACCESS_WRITE, riscv::PRIV_LVL_S);
        smp(); check("cw_ready", req_ready_o, 2'b10);
        nxt(); req_valid_i[1] = 0;
        smp();
        nxt(); cfg_write_i = 1; bad_en = 0;
        smp(); check("cw_second", chk_addr_o, 34'h0_8000_1001);
        nxt(); cfg_write_i = 0;
        smp(); check("cw_refirst_v", chk_valid_o, 1); check("cw_refirst", chk_addr_o, 34'h0_8000_0FFE);
        nxt();
        smp(); check("cw_resecond", chk_addr_o, 34'h0_8000_1001);
        nxt();
        smp(); check("cw_rsp_valid", rsp_valid_o, 2'b10); check("cw_rsp_allow", rsp_allow_o, 1);

        // flush during FIRST, pending request accepted next cycle
        nxt();
        set_req(0, 34'h0_8000_0000, 2'd2, riscv::ACCESS_READ, riscv::PRIV_LVL_S);
        smp(); check("fl_ready", req_ready_o, 2'b01);
        nxt(); req_valid_i[0] = 0; flush_i = 1;
        set_req(1, 34'h0_8000_0FFE, 2'd2, riscv::ACCESS_READ, riscv::PRIV_LVL_U);
        smp(); check("fl_busy_ready", req_ready_o, 2'b00);
        nxt(); flush_i = 0;
        smp(); check("fl_no_rsp", rsp_valid_o, 0); check("fl_accept", req_ready_o, 2'b10);

        // reset during SECOND
        nxt(); req_valid_i[1] = 0;
        smp(); check("rs_first", chk_addr_o, 34'h0_8000_0FFE);
        nxt(); rst_i = 1;
        smp(); check("rs_second_v", chk_valid_o, 1);
        nxt(); rst_i = 0;
        smp();
        check("rs_rsp_valid", rsp_valid_o, 0); check("rs_chk_valid", chk_valid_o, 0);
        check("rs_chk_addr", chk_addr_o, 0); check("rs_rsp_allow", rsp_allow_o, 0);
        check("rs_ready", req_ready_o, 0);
        repeat (2) begin nxt(); smp(); check("rs_no_rsp", rsp_valid_o, 0); end

        // round-robin with both requesters always valid
        nxt(); bad_en = 0;
        set_req(0, 34'h0_8000_0100, 2'd2, riscv::ACCESS_READ, riscv::PRIV_LVL_S);
        set_req(1, 34'h0_8000_0200, 2'd2, riscv::ACCESS_WRITE, riscv::PRIV_LVL_S);
        ng = 0;
        for (int c = 0; c < 30 && ng < 4; c++) begin
            smp();
            if (req_ready_o != 0) begin
                gidx[ng] = req_ready_o[1] ? 1 : 0;
                gcyc[ng] = c;
                ng++;
            end
            nxt();
        end
        check("rr_count", ng, 4);
        for (int i = 0; i < ng; i++) begin
            check("rr_grant", gidx[i], i % 2);
            if (i > 0) check("rr_spacing", gcyc[i] - gcyc[i-1], 3);
        end
        req_valid_i = '0;
        repeat (4) nxt();

        // randomized traffic against the model
        gs = '0;
        for (int c = 0; c < 4000; c++) begin
            smp(); gs = req_ready_o;
            nxt();
            for (int i = 0; i < NR_REQ; i++) begin
                if (gs[i]) req_valid_i[i] = 1'b0;
                if (!req_valid_i[i] && $urandom_range(0, 2) == 0) new_req(i);
            end
            flush_i = ($urandom_range(0, 24) == 0);
            cfg_write_i = ($urandom_range(0, 7) == 0);
            if (cfg_write_i) begin
                bad_en = 1'($urandom_range(0, 1));
                bad_sel = 3'($urandom_range(0, 7));
            end
            rst_i = ($urandom_range(0, 299) == 0);
        end
        req_valid_i = '0; flush_i = 0; cfg_write_i = 0; rst_i = 0;
        repeat (6) begin nxt(); smp(); end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
